// File: rtl/test_end_pkg.sv
// Shared types for the end-of-test controller: FSM states, verdict reason
// codes and the fail-source index width.
package test_end_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int REASON_W   = 3;
    localparam int FAIL_SRC_W = 4;

    typedef enum logic [REASON_W-1:0] {
        REASON_NONE    = 3'd0,
        REASON_PASS    = 3'd1,
        REASON_FAIL    = 3'd2,
        REASON_TIMEOUT = 3'd3,
        REASON_WDOG    = 3'd4
    } reason_t;

endpackage

// File: rtl/test_end_prio_enc.sv
// Lowest-index priority encoder: reports the index of the lowest set bit of
// req, or 0 when no bit is set.
module test_end_prio_enc
    import test_end_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0]      req,
    output logic [FAIL_SRC_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        // NOTE: idx gets a default before the loop so every path assigns it; otherwise a latch is inferred.
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = FAIL_SRC_W'(i);
            end
        end
    end

endmodule

// File: rtl/test_end_controller.sv
// End-of-test controller: holds the harness in reset, counts run cycles,
// collects per-source success/failure, latches a single verdict and raises
// finish_req after a drain window.
// Optional idle watchdog: define TEST_END_WATCHDOG_EN.
module test_end_controller
    import test_end_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int RESET_CYCLES = 8,
    parameter int DRAIN_CYCLES = 16,
    parameter int CNT_W        = 64,
    parameter int WDOG_W       = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [CNT_W-1:0]      max_cycles,
    input  logic [N_SRC-1:0]      success_i,
    input  logic [N_SRC-1:0]      fail_i,
    input  logic                  progress_i,
    input  logic [WDOG_W-1:0]     wdog_limit,
    output logic                  dut_reset,
    output logic                  running,
    output logic [CNT_W-1:0]      cycle_count,
    output logic [N_SRC-1:0]      done_vec,
    output logic                  verdict_valid,
    output logic                  pass,
    output logic [REASON_W-1:0]   reason,
    output logic [FAIL_SRC_W-1:0] fail_src,
    output logic                  finish_req
);

    localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    state_t                  state_q, state_d;
    reason_t                 reason_q, reason_d;
    logic [HOLD_W-1:0]       hold_cnt_q;
    logic [DRAIN_W-1:0]      drain_cnt_q;
    logic [CNT_W-1:0]        cycle_cnt_q;
    logic [CNT_W-1:0]        max_q;
    logic [N_SRC-1:0]        done_q;
    logic                    valid_q;
    logic                    pass_q;
    logic [FAIL_SRC_W-1:0]   fail_src_q;
    logic [FAIL_SRC_W-1:0]   enc_idx;
    logic                    cond_f, cond_t, cond_w, cond_s;
    logic                    end_hit;

    test_end_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
        .req (fail_i),
        .idx (enc_idx)
    );

`ifdef TEST_END_WATCHDOG_EN
    logic [WDOG_W-1:0] idle_q;

    // Idle counter: zero through HOLD so it starts clean in RUN, cleared by progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else if (state_q == HOLD || progress_i) begin
            idle_q <= '0;
        end else if (state_q == RUN && idle_q != '1) begin
            idle_q <= idle_q + WDOG_W'(1);
        end
    end

    assign cond_w = (wdog_limit != '0) && (idle_q >= wdog_limit);
`else
    logic unused_wdog;
    assign unused_wdog = ^{progress_i, wdog_limit};
    assign cond_w      = 1'b0;
`endif

    assign cond_f  = |fail_i;
    assign cond_t  = (max_q != '0) && (cycle_cnt_q >= max_q);
    assign cond_s  = &(done_q | success_i);
    assign end_hit = (reason_d != REASON_NONE);

    // Next-state and verdict arbitration; only RUN can produce a reason.
    always_comb begin
        state_d  = state_q;
        reason_d = REASON_NONE;
        case (state_q)
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                if (cond_f)      reason_d = REASON_FAIL;
                else if (cond_t) reason_d = REASON_TIMEOUT;
                else if (cond_w) reason_d = REASON_WDOG;
                else if (cond_s) reason_d = REASON_PASS;
                if (reason_d != REASON_NONE) begin
                    state_d = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
            end
            DONE:    state_d = DONE;
            default: state_d = HOLD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses '<=' so every register samples pre-edge values; '=' here would create order-dependent races.
        if (!reset_n) state_q <= HOLD;
        else          state_q <= state_d;
    end

    // Hold and drain phase counters; each stops at its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (state_q == HOLD && hold_cnt_q != HOLD_LAST) begin
                hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
            if (state_q == DRAIN && drain_cnt_q != DRAIN_LAST) begin
                drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
            end
        end
    end

    // Run bookkeeping: timeout limit latch, saturating cycle count, sticky successes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max_q       <= '0;
            cycle_cnt_q <= '0;
            done_q      <= '0;
        end else begin
            if (state_q == HOLD && state_d == RUN) begin
                max_q <= max_cycles;
            end
            // The count freezes on the verdict cycle so it reports the value that ended the run.
            if (state_q == RUN && !end_hit && cycle_cnt_q != '1) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (state_q == RUN) begin
                done_q <= done_q | success_i;
            end
        end
    end

    // Verdict registers, written once on the cycle a reason is chosen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            pass_q     <= 1'b0;
            reason_q   <= REASON_NONE;
            fail_src_q <= '0;
        end else if (end_hit) begin
            valid_q    <= 1'b1;
            pass_q     <= (reason_d == REASON_PASS);
            reason_q   <= reason_d;
            fail_src_q <= (reason_d == REASON_FAIL) ? enc_idx : '0;
        end
    end

    assign dut_reset     = (state_q == HOLD);
    assign running       = (state_q == RUN);
    assign finish_req    = (state_q == DONE);
    assign cycle_count   = cycle_cnt_q;
    assign done_vec      = done_q;
    assign verdict_valid = valid_q;
    assign pass          = pass_q;
    assign reason        = reason_q;
    assign fail_src      = fail_src_q;

endmodule

// File: tb/tb_test_end_controller.sv
// Scoreboard bench for test_end_controller (default build, watchdog off).
// Stimulus pushes expected run/verdict/finish events with their cycle;
// a monitor pops and compares on each rising running/verdict_valid/finish_req.
module tb_test_end_controller;

    localparam int N_SRC = 4;
    localparam int CNT_W = 64;

    typedef enum int { EV_RUN, EV_VERDICT, EV_FINISH } ev_kind_t;

    typedef struct {
        ev_kind_t   kind;
        int         cyc;
        logic [2:0] reason;
        logic       pass;
        logic [3:0] fail_src;
        logic [63:0] count;
        logic [3:0] done;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [CNT_W-1:0]  max_cycles = '0;
    logic [N_SRC-1:0]  success_i = '0;
    logic [N_SRC-1:0]  fail_i = '0;
    logic              progress_i = 1'b0;
    logic [19:0]       wdog_limit = '0;
    logic              dut_reset;
    logic              running;
    logic [CNT_W-1:0]  cycle_count;
    logic [N_SRC-1:0]  done_vec;
    logic              verdict_valid;
    logic              pass;
    logic [2:0]        reason;
    logic [3:0]        fail_src;
    logic              finish_req;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    test_end_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .max_cycles    (max_cycles),
        .success_i     (success_i),
        .fail_i        (fail_i),
        .progress_i    (progress_i),
        .wdog_limit    (wdog_limit),
        .dut_reset     (dut_reset),
        .running       (running),
        .cycle_count   (cycle_count),
        .done_vec      (done_vec),
        .verdict_valid (verdict_valid),
        .pass          (pass),
        .reason        (reason),
        .fail_src      (fail_src),
        .finish_req    (finish_req)
    );

    always #5 clk = ~clk;

    // Cycle index since reset release: cycle k is the interval after the k-th posedge.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) cyc = 0;
        else          cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_ev(ev_kind_t kind, int c, logic [2:0] rsn, logic p,
                                      logic [3:0] src, logic [63:0] cnt, logic [3:0] dn);
        exp_t e;
        e.kind = kind; e.cyc = c; e.reason = rsn; e.pass = p;
        e.fail_src = src; e.count = cnt; e.done = dn;
        sb_q.push_back(e);
    endfunction

    task automatic take(input ev_kind_t kind);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
        end else begin
            e = sb_q.pop_front();
            check("ev_kind",     64'(kind),        64'(e.kind));
            check("ev_cycle",    64'(cyc),         64'(e.cyc));
            check("ev_reason",   64'(reason),      64'(e.reason));
            check("ev_pass",     64'(pass),        64'(e.pass));
            check("ev_fail_src", 64'(fail_src),    64'(e.fail_src));
            check("ev_count",    64'(cycle_count), e.count);
            check("ev_done_vec", 64'(done_vec),    64'(e.done));
            check("ev_dut_reset", 64'(dut_reset),  64'(0));
        end
    endtask

    // Monitor: compares on each rising edge of the observable status outputs.
    initial begin
        bit pr = 1'b0, pv = 1'b0, pf = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                pr = 1'b0; pv = 1'b0; pf = 1'b0;
            end else begin
                if (running && !pr)       take(EV_RUN);
                if (verdict_valid && !pv) take(EV_VERDICT);
                if (finish_req && !pf)    take(EV_FINISH);
                pr = running; pv = verdict_valid; pf = finish_req;
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_dut_reset"},  64'(dut_reset),     64'(1));
        check({tag, "_running"},    64'(running),       64'(0));
        check({tag, "_count"},      cycle_count,        64'(0));
        check({tag, "_done_vec"},   64'(done_vec),      64'(0));
        check({tag, "_valid"},      64'(verdict_valid), 64'(0));
        check({tag, "_pass"},       64'(pass),          64'(0));
        check({tag, "_reason"},     64'(reason),        64'(0));
        check({tag, "_fail_src"},   64'(fail_src),      64'(0));
        check({tag, "_finish_req"}, 64'(finish_req),    64'(0));
    endtask

    // Release reset between edges with a given timeout limit; RUN must begin in cycle 8.
    task automatic start_run(input logic [63:0] max_val);
        max_cycles = max_val;
        success_i  = '0;
        fail_i     = '0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        expect_ev(EV_RUN, 8, 3'd0, 1'b0, 4'd0, 64'd0, 4'h0);
    endtask

    // Asynchronous reset mid-cycle, immediate check, then a fresh run.
    task automatic do_reset(input string tag, input logic [63:0] max_val);
        check({tag, "_sb_empty"}, 64'(sb_q.size()), 64'(0));
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset_values(tag);
        start_run(max_val);
    endtask

    initial begin
        #3 check_reset_values("por");
        start_run(64'd0);

        // Run 1: success/fail ignored in HOLD, then successes 0,2,1,3 at RUN cycles 3,5,7,9.
        expect_ev(EV_VERDICT, 18, 3'd1, 1'b1, 4'd0, 64'd9, 4'hF);
        expect_ev(EV_FINISH,  34, 3'd1, 1'b1, 4'd0, 64'd9, 4'hF);
        wait_until(2);  success_i = 4'hF; fail_i = 4'hF;
        wait_until(6);  success_i = 4'h0; fail_i = 4'h0;
        wait_until(7);
        check("hold_dut_reset", 64'(dut_reset), 64'(1));
        check("hold_running",   64'(running),   64'(0));
        wait_until(8);
        check("hold_ignored_done", 64'(done_vec), 64'(0));
        wait_until(11); success_i = 4'b0001;
        wait_until(12); success_i = 4'b0000;
        wait_until(13); success_i = 4'b0100;
        wait_until(14); success_i = 4'b0000;
        check("partial_done_vec", 64'(done_vec), 64'(4'b0101));
        wait_until(15); success_i = 4'b0010;
        wait_until(16); success_i = 4'b0000;
        wait_until(17); success_i = 4'b1000;
        wait_until(18); success_i = 4'b0000;
        wait_until(36);
        check("done_finish_held", 64'(finish_req), 64'(1));

        // Run 2: reset from DONE; max_cycles=5 times out on the 6th RUN cycle; later changes to
        // max_cycles and inputs during DRAIN have no effect.
        do_reset("rst_done", 64'd5);
        expect_ev(EV_VERDICT, 14, 3'd3, 1'b0, 4'd0, 64'd5, 4'h0);
        expect_ev(EV_FINISH,  30, 3'd3, 1'b0, 4'd0, 64'd5, 4'h0);
        wait_until(10); max_cycles = 64'd0;
        wait_until(15); success_i = 4'hF; fail_i = 4'hF;
        wait_until(20); success_i = 4'h0; fail_i = 4'h0;
        wait_until(32);

        // Run 3: failure 0110 together with the final success bit; failure wins, source 1.
        do_reset("rst_done2", 64'd0);
        expect_ev(EV_VERDICT, 15, 3'd2, 1'b0, 4'd1, 64'd6, 4'hF);
        expect_ev(EV_FINISH,  31, 3'd2, 1'b0, 4'd1, 64'd6, 4'hF);
        wait_until(9);  success_i = 4'b0111;
        wait_until(14); success_i = 4'b1111; fail_i = 4'b0110;
        wait_until(15); success_i = 4'b0000; fail_i = 4'b0000;
        wait_until(32);

        // Run 4: failure on the top source, then reset while draining.
        do_reset("rst_done3", 64'd0);
        expect_ev(EV_VERDICT, 11, 3'd2, 1'b0, 4'd3, 64'd2, 4'h0);
        wait_until(10); fail_i = 4'b1000;
        wait_until(11); fail_i = 4'b0000;
        wait_until(15);
        check("drain_valid",   64'(verdict_valid), 64'(1));
        check("drain_running", 64'(running),       64'(0));
        check("drain_no_fin",  64'(finish_req),    64'(0));

        // Run 5: reset from DRAIN; timeout disabled, long idle run, then a full pass.
        do_reset("rst_drain", 64'd0);
        expect_ev(EV_VERDICT, 309, 3'd1, 1'b1, 4'd0, 64'd300, 4'hF);
        expect_ev(EV_FINISH,  325, 3'd1, 1'b1, 4'd0, 64'd300, 4'hF);
        wait_until(308);
        check("no_timeout_valid", 64'(verdict_valid), 64'(0));
        check("no_timeout_count", cycle_count,        64'd300);
        success_i = 4'hF;
        wait_until(309); success_i = 4'h0;
        wait_until(327);
        check("final_sb_empty", 64'(sb_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no end of stimulus expected finish before 200000");
        $fatal(1);
    end

endmodule
